sparse_match_iter: RTL and testbench
====================================

SPARSE_MATCH_ITER -- requirements
Module: sparse_match_iter

Interface
REQ-001 Parameter: DATA_WIDTH, 32, flag bits per vector (channels); legal range 2..256.
REQ-002 Parameter: REL_MODE, 0, 0 = absolute compressed addresses, 1 = relative skip offsets.
REQ-003 Derived: AW = clog2(DATA_WIDTH); CW = clog2(DATA_WIDTH+1).
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_sta  input  1  start pulse; samples i_act_flag/i_wei_flag.
REQ-007 i_act_flag  input  DATA_WIDTH  activation nonzero flags, bit i = channel i.
REQ-008 i_wei_flag  input  DATA_WIDTH  weight nonzero flags, bit i = channel i.
REQ-009 i_rdy  input  1  consumer ready for current beat.
REQ-010 o_val  output  1  current beat valid.
REQ-011 o_ch  output  AW  channel index of current match.
REQ-012 o_off_act  output  AW  activation address/offset of current match.
REQ-013 o_off_wei  output  AW  weight address/offset of current match.
REQ-014 o_last  output  1  current beat is final match of vector.
REQ-015 o_cnt  output  CW  total match count of loaded vector.
REQ-016 o_empty  output  1  one-cycle pulse: loaded vector has zero matches.
REQ-017 o_busy  output  1  high while in RUN.

Function
REQ-018 Match vector M = act & wei, latched with act, wei into registers on the i_sta edge; remaining mask R initialised to M.
REQ-019 States IDLE, RUN; IDLE->RUN on i_sta with M!=0; IDLE stays IDLE on i_sta with M==0 and o_empty pulses the following cycle.
REQ-020 i_sta in RUN aborts current vector and reloads (same rules as IDLE); i_sta always has priority over handshake.
REQ-021 Matches emitted LSB-first: current channel c = lowest set bit of R.
REQ-022 o_val = 1 exactly while in RUN; first beat visible the cycle after the i_sta edge (latency 1).
REQ-023 Handshake: beat consumed on edge with o_val & i_rdy; bit c cleared from R; next beat presented the following cycle with no bubble.
REQ-024 o_val & !i_rdy: o_ch, o_off_act, o_off_wei, o_last, o_cnt held stable.
REQ-025 REL_MODE=0: o_off_act = popcount(act[c-1:0]); o_off_wei = popcount(wei[c-1:0]); 0 when c=0.
REQ-026 REL_MODE=1: first beat same as REL_MODE=0; later beats = count of set bits strictly between previous match channel p and c (act resp. wei), i.e. abs(c) - abs(p) - 1.
REQ-027 o_last = 1 iff R has exactly one set bit; consuming a last beat returns to IDLE, o_val low next cycle.
REQ-028 o_cnt = popcount(M), updated on i_sta edge, held until next i_sta.
REQ-029 All-ones act and wei: DATA_WIDTH beats, c = 0..DATA_WIDTH-1, REL_MODE=1 offsets all 0, o_cnt = DATA_WIDTH (CW width required).
REQ-030 Outputs in IDLE: o_val=0, o_last=0, o_ch/o_off_* = 0.

Reset
REQ-031 rst_n low, any time including mid-vector: state IDLE, R/act/wei/prev = 0, all outputs 0 immediately; no beat after release until new i_sta.

Verification (DATA_WIDTH=8)
REQ-032 REL_MODE=0, act=8'b1011_0110, wei=8'b1101_0011, i_rdy=1 -> o_cnt=3; beats (ch,act,wei) = (1,0,1),(4,2,2),(7,4,4); o_last on third only.
REQ-033 REL_MODE=1, same flags -> beats (1,0,1),(4,1,0),(7,1,1).
REQ-034 act=8'hF0, wei=8'h0F -> o_empty one cycle, o_val never high, o_cnt=0.
REQ-035 Same flags as REQ-032 with i_rdy low 3 cycles on beat 2 -> beat (4,2,2) held 4 cycles, then beat 7; total beats 3.
REQ-036 i_sta with act=wei=8'h81 asserted while beat 2 of REQ-032 pending -> next beats (0,0,0),(7,1,1); o_cnt=2.
REQ-037 rst_n asserted during beat 2 -> o_val=0 asynchronously, all outputs 0, stays idle after release.

Source files
------------

// File: rtl/sparse_match_iter_if.sv
// Bus bundle for sparse_match_iter.
//   i_sta       : start pulse, samples i_act_flag / i_wei_flag
//   i_act_flag  : activation nonzero flags (bit i = channel i)
//   i_wei_flag  : weight nonzero flags (bit i = channel i)
//   i_rdy       : consumer ready for the current beat
//   o_val       : beat valid
//   o_ch        : channel of the current match
//   o_off_act   : activation address/offset of the current match
//   o_off_wei   : weight address/offset of the current match
//   o_last      : final match of the vector
//   o_cnt       : total match count of the loaded vector
//   o_empty     : one-cycle pulse, loaded vector has no matches
//   o_busy      : iterator is walking a vector
// master = producer/consumer side, slave = iterator.
interface sparse_match_iter_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned AW = $clog2(DATA_WIDTH);
  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

  logic                  i_sta;
  logic [DATA_WIDTH-1:0] i_act_flag;
  logic [DATA_WIDTH-1:0] i_wei_flag;
  logic                  i_rdy;
  logic                  o_val;
  logic [AW-1:0]         o_ch;
  logic [AW-1:0]         o_off_act;
  logic [AW-1:0]         o_off_wei;
  logic                  o_last;
  logic [CW-1:0]         o_cnt;
  logic                  o_empty;
  logic                  o_busy;

  modport master (
    output i_sta, i_act_flag, i_wei_flag, i_rdy,
    input  o_val, o_ch, o_off_act, o_off_wei, o_last, o_cnt, o_empty, o_busy
  );

  modport slave (
    input  i_sta, i_act_flag, i_wei_flag, i_rdy,
    output o_val, o_ch, o_off_act, o_off_wei, o_last, o_cnt, o_empty, o_busy
  );
endinterface

// File: rtl/sparse_match_iter.sv
// Sparse match iterator: latches activation/weight nonzero flags on i_sta and
// walks the channels where both are set, LSB first, one beat per i_rdy.
// Offsets are absolute compressed addresses (REL_MODE=0) or skip counts
// since the previous match (REL_MODE=1).
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : sparse_match_iter_if.slave (start/flags/ready in, beat out)
module sparse_match_iter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REL_MODE   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sparse_match_iter_if.slave   bus
);
  localparam int unsigned AW = $clog2(DATA_WIDTH);
  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  // Index of the lowest set bit (0 when none).
  function automatic logic [AW-1:0] f_lowest(input logic [DATA_WIDTH-1:0] v);
    logic [AW-1:0] idx;
    idx = '0;
    for (int i = int'(DATA_WIDTH) - 1; i >= 0; i--) begin
      if (v[i]) idx = AW'(i);
    end
    return idx;
  endfunction

  // Count set bits strictly below hi, and strictly above lo when use_lo.
  function automatic logic [CW-1:0] f_count(input logic [DATA_WIDTH-1:0] v,
                                            input logic             use_lo,
                                            input logic [AW-1:0]    lo,
                                            input logic [AW-1:0]    hi);
    logic [CW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      if (v[i] && (i < int'(hi)) && (!use_lo || (i > int'(lo)))) cnt = cnt + CW'(1);
    end
    return cnt;
  endfunction

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_act;
  logic [DATA_WIDTH-1:0] r_wei;
  logic [DATA_WIDTH-1:0] r_rem;
  logic [AW-1:0]         r_prev;
  logic                  r_has_prev;

  logic                  r_val;
  logic [AW-1:0]         r_ch;
  logic [AW-1:0]         r_off_act;
  logic [AW-1:0]         r_off_wei;
  logic                  r_last;
  logic [CW-1:0]         r_cnt;
  logic                  r_empty;
  logic                  r_busy;

  state_t                w_state_n;
  logic [DATA_WIDTH-1:0] w_match;
  logic [DATA_WIDTH-1:0] w_act_n;
  logic [DATA_WIDTH-1:0] w_wei_n;
  logic [DATA_WIDTH-1:0] w_rem_n;
  logic [AW-1:0]         w_prev_n;
  logic                  w_has_prev_n;
  logic [AW-1:0]         w_ch_n;
  logic [AW-1:0]         w_off_act_n;
  logic [AW-1:0]         w_off_wei_n;
  logic                  w_last_n;
  logic [CW-1:0]         w_cnt_n;
  logic                  w_empty_n;
  logic                  w_use_prev;

  // Next state, then the beat that next state will present.
  always_comb begin
    w_match      = bus.i_act_flag & bus.i_wei_flag;
    w_act_n      = r_act;
    w_wei_n      = r_wei;
    w_rem_n      = r_rem;
    w_prev_n     = r_prev;
    w_has_prev_n = r_has_prev;
    w_cnt_n      = r_cnt;
    w_empty_n    = 1'b0;
    w_ch_n       = '0;
    w_off_act_n  = '0;
    w_off_wei_n  = '0;
    w_last_n     = 1'b0;
    w_use_prev   = 1'b0;

    if (bus.i_sta) begin
      // Start wins over the handshake, aborting any vector in flight.
      w_act_n      = bus.i_act_flag;
      w_wei_n      = bus.i_wei_flag;
      w_rem_n      = w_match;
      w_prev_n     = '0;
      w_has_prev_n = 1'b0;
      w_cnt_n      = CW'($countones(w_match));
      w_empty_n    = (w_match == '0);
    end else if ((r_state == ST_RUN) && bus.i_rdy) begin
      // Beat consumed: drop the lowest remaining bit, remember its channel.
      w_rem_n      = r_rem & (r_rem - DATA_WIDTH'(1));
      w_prev_n     = r_ch;
      w_has_prev_n = 1'b1;
    end

    w_state_n = (w_rem_n != '0) ? ST_RUN : ST_IDLE;

    if (w_state_n == ST_RUN) begin
      w_ch_n      = f_lowest(w_rem_n);
      w_use_prev  = (REL_MODE != 0) && w_has_prev_n;
      w_off_act_n = AW'(f_count(w_act_n, w_use_prev, w_prev_n, w_ch_n));
      w_off_wei_n = AW'(f_count(w_wei_n, w_use_prev, w_prev_n, w_ch_n));
      w_last_n    = ((w_rem_n & (w_rem_n - DATA_WIDTH'(1))) == '0);
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_act      <= '0;
      r_wei      <= '0;
      r_rem      <= '0;
      r_prev     <= '0;
      r_has_prev <= 1'b0;
      r_val      <= 1'b0;
      r_ch       <= '0;
      r_off_act  <= '0;
      r_off_wei  <= '0;
      r_last     <= 1'b0;
      r_cnt      <= '0;
      r_empty    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_act      <= w_act_n;
      r_wei      <= w_wei_n;
      r_rem      <= w_rem_n;
      r_prev     <= w_prev_n;
      r_has_prev <= w_has_prev_n;
      r_val      <= (w_state_n == ST_RUN);
      r_ch       <= w_ch_n;
      r_off_act  <= w_off_act_n;
      r_off_wei  <= w_off_wei_n;
      r_last     <= w_last_n;
      r_cnt      <= w_cnt_n;
      r_empty    <= w_empty_n;
      r_busy     <= (w_state_n == ST_RUN);
    end
  end

  assign bus.o_val     = r_val;
  assign bus.o_ch      = r_ch;
  assign bus.o_off_act = r_off_act;
  assign bus.o_off_wei = r_off_wei;
  assign bus.o_last    = r_last;
  assign bus.o_cnt     = r_cnt;
  assign bus.o_empty   = r_empty;
  assign bus.o_busy    = r_busy;
endmodule

// File: tb/tb_sparse_match_iter.sv
// Bench for sparse_match_iter: one absolute-address and one relative-offset
// instance share stimulus; a queue-based model of the expected beat stream is
// compared on every falling edge, plus directed literal checks.
module tb_sparse_match_iter;
  localparam int unsigned DW = 8;

  typedef struct packed {
    logic [2:0] ch;
    logic [2:0] a_abs;
    logic [2:0] w_abs;
    logic [2:0] a_rel;
    logic [2:0] w_rel;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sta = 1'b0;
  logic [7:0] act = 8'h00;
  logic [7:0] wei = 8'h00;
  logic       rdy = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  beat_t      mq[$];
  logic [3:0] m_cnt = 4'd0;
  logic       m_empty = 1'b0;
  logic [9:0] log0[$];
  logic [9:0] log1[$];

  always #5 clk = ~clk;

  sparse_match_iter_if #(.DATA_WIDTH(DW)) bus0 ();
  sparse_match_iter_if #(.DATA_WIDTH(DW)) bus1 ();

  assign bus0.i_sta = sta;  assign bus0.i_act_flag = act;
  assign bus0.i_wei_flag = wei;  assign bus0.i_rdy = rdy;
  assign bus1.i_sta = sta;  assign bus1.i_act_flag = act;
  assign bus1.i_wei_flag = wei;  assign bus1.i_rdy = rdy;

  sparse_match_iter #(.DATA_WIDTH(DW), .REL_MODE(0)) u_abs (.clk(clk), .rst_n(rst_n), .bus(bus0));
  sparse_match_iter #(.DATA_WIDTH(DW), .REL_MODE(1)) u_rel (.clk(clk), .rst_n(rst_n), .bus(bus1));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Expected beat list straight from the flag vectors.
  function automatic void build(input logic [7:0] a, input logic [7:0] w);
    int    pa, pw, aa, wa;
    bit    have;
    logic [7:0] mask;
    beat_t b;
    mq.delete();
    have = 0; pa = 0; pw = 0;
    for (int c = 0; c < 8; c++) begin
      if (a[c] && w[c]) begin
        mask    = 8'((9'h1 << c) - 9'h1);
        aa      = $countones(a & mask);
        wa      = $countones(w & mask);
        b.ch    = 3'(c);
        b.a_abs = 3'(aa);
        b.w_abs = 3'(wa);
        b.a_rel = have ? 3'(aa - pa - 1) : 3'(aa);
        b.w_rel = have ? 3'(wa - pw - 1) : 3'(wa);
        mq.push_back(b);
        pa = aa; pw = wa; have = 1;
      end
    end
  endfunction

  // Model update and consumed-beat log.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_cnt   <= 4'd0;
      m_empty <= 1'b0;
    end else begin
      if (!sta && rdy && bus0.o_val)
        log0.push_back({bus0.o_ch, bus0.o_off_act, bus0.o_off_wei, bus0.o_last});
      if (!sta && rdy && bus1.o_val)
        log1.push_back({bus1.o_ch, bus1.o_off_act, bus1.o_off_wei, bus1.o_last});
      if (sta) begin
        build(act, wei);
        m_cnt   <= 4'($countones(act & wei));
        m_empty <= ((act & wei) == 8'h00);
      end else begin
        m_empty <= 1'b0;
        if (mq.size() > 0 && rdy) void'(mq.pop_front());
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    logic [16:0] e0, e1, g0, g1;
    logic        lst;
    if (rst_n) begin
      if (mq.size() > 0) begin
        lst = (mq.size() == 1);
        e0 = {1'b1, mq[0].ch, mq[0].a_abs, mq[0].w_abs, lst, m_cnt, m_empty, 1'b1};
        e1 = {1'b1, mq[0].ch, mq[0].a_rel, mq[0].w_rel, lst, m_cnt, m_empty, 1'b1};
      end else begin
        e0 = {1'b0, 9'd0, 1'b0, m_cnt, m_empty, 1'b0};
        e1 = e0;
      end
      g0 = {bus0.o_val, bus0.o_ch, bus0.o_off_act, bus0.o_off_wei, bus0.o_last,
            bus0.o_cnt, bus0.o_empty, bus0.o_busy};
      g1 = {bus1.o_val, bus1.o_ch, bus1.o_off_act, bus1.o_off_wei, bus1.o_last,
            bus1.o_cnt, bus1.o_empty, bus1.o_busy};
      chk("cycle_abs", 32'(g0), 32'(e0));
      chk("cycle_rel", 32'(g1), 32'(e1));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (!bus0.o_val && !bus1.o_val) return;
      step();
    end
    chk("idle_timeout", 32'(bus0.o_val | bus1.o_val), 32'd0);
  endtask

  task automatic start(input logic [7:0] a, input logic [7:0] w);
    sta = 1'b1; act = a; wei = w;
    step();
    sta = 1'b0;
  endtask

  initial begin
    // Pin the model with hand-computed beats.
    #1;
    build(8'hB6, 8'hD3);
    chk("model_n",  32'(mq.size()), 32'd3);
    chk("model_b0", 32'(mq[0]), 32'({3'd1, 3'd0, 3'd1, 3'd0, 3'd1}));
    chk("model_b1", 32'(mq[1]), 32'({3'd4, 3'd2, 3'd2, 3'd1, 3'd0}));
    chk("model_b2", 32'(mq[2]), 32'({3'd7, 3'd4, 3'd4, 3'd1, 3'd1}));
    build(8'h81, 8'h81);
    chk("model_81", 32'(mq[1]), 32'({3'd7, 3'd1, 3'd1, 3'd0, 3'd0}));
    mq.delete();

    // Reset state.
    repeat (2) step();
    chk("reset_abs", 32'({bus0.o_val, bus0.o_ch, bus0.o_off_act, bus0.o_off_wei,
                          bus0.o_last, bus0.o_cnt, bus0.o_empty, bus0.o_busy}), 32'd0);
    rst_n = 1'b1;
    step();

    // Basic stream, both modes.
    log0.delete(); log1.delete();
    rdy = 1'b1;
    start(8'hB6, 8'hD3);
    wait_idle(20);
    chk("basic_abs_n", 32'(log0.size()), 32'd3);
    chk("basic_rel_n", 32'(log1.size()), 32'd3);
    if (log0.size() == 3 && log1.size() == 3) begin
      chk("basic_abs0", 32'(log0[0]), 32'({3'd1, 3'd0, 3'd1, 1'b0}));
      chk("basic_abs1", 32'(log0[1]), 32'({3'd4, 3'd2, 3'd2, 1'b0}));
      chk("basic_abs2", 32'(log0[2]), 32'({3'd7, 3'd4, 3'd4, 1'b1}));
      chk("basic_rel1", 32'(log1[1]), 32'({3'd4, 3'd1, 3'd0, 1'b0}));
      chk("basic_rel2", 32'(log1[2]), 32'({3'd7, 3'd1, 3'd1, 1'b1}));
    end
    chk("basic_cnt", 32'(bus0.o_cnt), 32'd3);

    // No matches.
    start(8'hF0, 8'h0F);
    chk("empty_pulse", 32'({bus0.o_empty, bus0.o_val, bus0.o_cnt}), 32'({1'b1, 1'b0, 4'd0}));
    step();
    chk("empty_drop", 32'({bus0.o_empty, bus0.o_val}), 32'd0);

    // Back-pressure on beat 2.
    log0.delete();
    start(8'hB6, 8'hD3);
    step();
    rdy = 1'b0;
    chk("hold_0", 32'({bus0.o_ch, bus0.o_off_act, bus0.o_off_wei}), 32'({3'd4, 3'd2, 3'd2}));
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("hold_%0d", i), 32'({bus0.o_val, bus0.o_ch, bus0.o_off_act, bus0.o_off_wei}),
          32'({1'b1, 3'd4, 3'd2, 3'd2}));
    end
    rdy = 1'b1;
    step();
    chk("hold_next", 32'({bus0.o_ch, bus0.o_last}), 32'({3'd7, 1'b1}));
    step();
    chk("hold_done", 32'({bus0.o_val, 8'(log0.size())}), 32'({1'b0, 8'd3}));

    // Restart while beat 2 pending.
    start(8'hB6, 8'hD3);
    step();
    start(8'h81, 8'h81);
    chk("abort_abs0", 32'({bus0.o_ch, bus0.o_off_act, bus0.o_off_wei, bus0.o_cnt}),
        32'({3'd0, 3'd0, 3'd0, 4'd2}));
    step();
    chk("abort_abs1", 32'({bus0.o_ch, bus0.o_off_act, bus0.o_off_wei, bus0.o_last}),
        32'({3'd7, 3'd1, 3'd1, 1'b1}));
    chk("abort_rel1", 32'({bus1.o_ch, bus1.o_off_act, bus1.o_off_wei, bus1.o_last}),
        32'({3'd7, 3'd0, 3'd0, 1'b1}));
    step();
    chk("abort_done", 32'(bus0.o_val), 32'd0);

    // Asynchronous reset mid-vector.
    start(8'hB6, 8'hD3);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_abs", 32'({bus0.o_val, bus0.o_ch, bus0.o_off_act, bus0.o_off_wei,
                        bus0.o_last, bus0.o_cnt, bus0.o_empty, bus0.o_busy}), 32'd0);
    chk("rst_rel", 32'({bus1.o_val, bus1.o_cnt, bus1.o_busy}), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("rst_stay_idle", 32'(bus0.o_val | bus1.o_val), 32'd0);

    // All channels match.
    log1.delete();
    start(8'hFF, 8'hFF);
    chk("full_cnt", 32'(bus1.o_cnt), 32'd8);
    wait_idle(30);
    chk("full_n", 32'(log1.size()), 32'd8);
    for (int i = 0; i < 8 && i < log1.size(); i++)
      chk($sformatf("full_b%0d", i), 32'(log1[i]), 32'({3'(i), 3'd0, 3'd0, (i == 7)}));

    // Random traffic.
    for (int it = 0; it < 600; it++) begin
      sta = ($urandom_range(0, 5) == 0);
      act = 8'($urandom);
      wei = 8'($urandom);
      if ($urandom_range(0, 9) == 0) begin act = 8'hFF; wei = 8'hFF; end
      rdy = ($urandom_range(0, 9) < 7);
      if (it == 300) begin
        #3 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      step();
    end
    sta = 1'b0;
    rdy = 1'b1;
    wait_idle(30);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
